// File: rtl/hack_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : hack_ctrl_seq_if
// Description : Bus bundle between the Hack control sequencer and its
//               environment (ROM, data RAM, datapath).
// Revision    : 1.0 - initial release
// ============================================================================
interface hack_ctrl_seq_if #(
    parameter int W     = 16,
    parameter int CNT_W = 32
) ();
    logic             rom_req;
    logic             rom_ack;
    logic [W-1:0]     rom_data;
    logic             ram_req;
    logic             ram_we;
    logic             ram_ack;
    logic             zr;
    logic             ng;
    logic [W-1:0]     ir;
    logic [5:0]       alu_ctrl;
    logic             sel_am;
    logic             sel_a_alu;
    logic             load_a;
    logic             load_d;
    logic             load_m;
    logic             load_pc;
    logic             inc_pc;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output rom_req,
        input  rom_ack,
        input  rom_data,
        output ram_req,
        output ram_we,
        input  ram_ack,
        input  zr,
        input  ng,
        output ir,
        output alu_ctrl,
        output sel_am,
        output sel_a_alu,
        output load_a,
        output load_d,
        output load_m,
        output load_pc,
        output inc_pc,
        output instr_cnt
    );

    modport slave (
        input  rom_req,
        output rom_ack,
        output rom_data,
        input  ram_req,
        input  ram_we,
        output ram_ack,
        output zr,
        output ng,
        input  ir,
        input  alu_ctrl,
        input  sel_am,
        input  sel_a_alu,
        input  load_a,
        input  load_d,
        input  load_m,
        input  load_pc,
        input  inc_pc,
        input  instr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hack_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : hack_ctrl_seq
// Description : Multi-cycle Hack CPU control sequencer: fetch, decode, data
//               RAM read/write handshakes and datapath load strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_ctrl_seq #(
    parameter int W     = 16,
    parameter int CNT_W = 32
) (
    input  logic            clk50m,
    input  logic            rst,
    hack_ctrl_seq_if.master bus
);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_memrd  = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_memwr  = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [W-1:0]     r_ir;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_fetch;
    logic w_decode;
    logic w_memrd;
    logic w_exec;
    logic w_memwr;
    logic w_a_retire;
    logic w_commit;
    logic w_take;
    logic w_retire;

    // Every state decode is masked by rst so requests and strobes drop in the reset cycle
    assign w_fetch  = (r_state == c_st_fetch)  & ~rst;
    assign w_decode = (r_state == c_st_decode) & ~rst;
    assign w_memrd  = (r_state == c_st_memrd)  & ~rst;
    assign w_exec   = (r_state == c_st_exec)   & ~rst;
    assign w_memwr  = (r_state == c_st_memwr)  & ~rst;

    assign w_a_retire = w_decode & ~r_ir[15];
    // A C-instruction with an M destination defers its A/D/PC commit until the RAM write lands
    assign w_commit   = (w_exec & ~r_ir[3]) | (w_memwr & bus.ram_ack);
    assign w_take     = (r_ir[2] & bus.ng) | (r_ir[1] & bus.zr) | (r_ir[0] & ~bus.ng & ~bus.zr);
    assign w_retire   = w_a_retire | w_commit;

    assign bus.rom_req   = w_fetch;
    assign bus.ram_req   = w_memrd | w_memwr;
    assign bus.ram_we    = w_memwr;
    assign bus.load_m    = w_memrd & bus.ram_ack;
    assign bus.load_a    = w_a_retire | (w_commit & r_ir[5]);
    assign bus.sel_a_alu = w_commit;
    assign bus.load_d    = w_commit & r_ir[4];
    assign bus.load_pc   = w_commit & w_take;
    assign bus.inc_pc    = w_a_retire | (w_commit & ~w_take);
    assign bus.ir        = r_ir;
    assign bus.alu_ctrl  = r_ir[11:6];
    assign bus.sel_am    = r_ir[12];
    assign bus.instr_cnt = r_instr_cnt;

    always_ff @(posedge clk50m) begin
        if (rst) begin
            r_state     <= c_st_fetch;
            r_ir        <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + c_cnt_one;
            end
            case (r_state)
                c_st_fetch: begin
                    if (bus.rom_ack) begin
                        r_ir    <= bus.rom_data;
                        r_state <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    if (!r_ir[15]) begin
                        r_state <= c_st_fetch;
                    end else if (r_ir[12]) begin
                        r_state <= c_st_memrd;
                    end else begin
                        r_state <= c_st_exec;
                    end
                end
                c_st_memrd: begin
                    if (bus.ram_ack) begin
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    r_state <= r_ir[3] ? c_st_memwr : c_st_fetch;
                end
                c_st_memwr: begin
                    if (bus.ram_ack) begin
                        r_state <= c_st_fetch;
                    end
                end
                default: begin
                    r_state <= c_st_fetch;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
